dmem_mmio_responder: RTL and testbench



---
 rtl/mmio_pkg.sv | 38 +++
 rtl/mmio_tx_fifo.sv | 66 ++++++
 rtl/dmem_mmio_responder.sv | 155 +++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the dmem MMIO responder: register offsets, STATUS
// bit layout and the default window base.
package mmio_pkg;

   localparam logic [11:0] DEFAULT_BASE_ADDR = 12'hFF0;

   localparam logic [3:0] OFF_LED    = 4'd0;
   localparam logic [3:0] OFF_TCOUNT = 4'd1;
   localparam logic [3:0] OFF_TCMP   = 4'd2;
   localparam logic [3:0] OFF_STATUS = 4'd3;
   localparam logic [3:0] OFF_TXDATA = 4'd4;
   localparam logic [3:0] OFF_IRQCLR = 4'd5;

   localparam int ST_EMPTY    = 0;
   localparam int ST_FULL     = 1;
   localparam int ST_IRQ      = 2;
   localparam int ST_COUNT_LO = 3;
   localparam int ST_COUNT_HI = 5;
   localparam int ST_OVF      = 6;

   function automatic logic [31:0] pack_status(
      input logic       empty,
      input logic       full,
      input logic       irq,
      input logic [2:0] count,
      input logic       ovf
   );
      logic [31:0] s;
      s                         = '0;
      s[ST_EMPTY]               = empty;
      s[ST_FULL]                = full;
      s[ST_IRQ]                 = irq;
      s[ST_COUNT_HI:ST_COUNT_LO] = count;
      s[ST_OVF]                 = ovf;
      return s;
   endfunction

endpackage

// File: rtl/mmio_tx_fifo.sv
// Byte-wide circular transmit FIFO. Pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
module mmio_tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                   i_clock,
   input  logic                   i_reset_n,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [7:0]             i_wdata,
   output logic [7:0]             o_rdata,
   output logic                   o_empty,
   output logic                   o_full,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [7:0]       r_mem [DEPTH];
   logic             w_do_pop;
   logic             w_do_push;
   logic [DEPTH-1:0] w_slot_we;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_count = r_wr_ptr - r_rd_ptr;
   assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

   // A push into a full FIFO is accepted only when the head leaves on the
   // same edge; the tail slot then aliases the slot being vacated.
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         assign w_slot_we[gi] = w_do_push && (r_wr_ptr[AW-1:0] == AW'(gi));
      end
   endgenerate

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (w_slot_we[i]) begin
               r_mem[i] <= i_wdata;
            end
         end
      end
   end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Peripheral window on the dmem port: LED register, free-running timer with
// compare interrupt, and a byte TX FIFO. Read data lags the address by one clock.
module dmem_mmio_responder
   import mmio_pkg::*;
#(
   parameter logic [11:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic [11:0] i_address,
   input  logic [31:0] i_data,
   input  logic        i_wren,
   output logic [31:0] o_q,
   output logic        o_hit,
   output logic [15:0] o_led_out,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic        o_irq
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic        w_sel;
   logic [3:0]  w_off;
   logic        w_wr;
   logic        w_wr_led;
   logic        w_wr_tcount;
   logic        w_wr_tcmp;
   logic        w_wr_status;
   logic        w_wr_txdata;
   logic        w_wr_irqclr;
   logic        w_irq_set;
   logic        w_irq_clr;
   logic        w_ovf_set;
   logic        w_ovf_clr;
   logic        w_push;
   logic        w_pop;
   logic        w_fifo_empty;
   logic        w_fifo_full;
   logic [CW-1:0] w_fifo_count;
   logic [2:0]  w_count3;
   logic [31:0] w_status;
   logic [31:0] w_rd_data;

   logic [31:0] r_q;
   logic        r_hit;
   logic [15:0] r_led;
   logic [31:0] r_tcount;
   logic [31:0] r_tcmp;
   logic        r_irq;
   logic        r_ovf;

   assign w_sel = (i_address[11:4] == BASE_ADDR[11:4]);
   assign w_off = i_address[3:0];
   assign w_wr  = i_wren && w_sel;

   assign w_wr_led    = w_wr && (w_off == OFF_LED);
   assign w_wr_tcount = w_wr && (w_off == OFF_TCOUNT);
   assign w_wr_tcmp   = w_wr && (w_off == OFF_TCMP);
   assign w_wr_status = w_wr && (w_off == OFF_STATUS);
   assign w_wr_txdata = w_wr && (w_off == OFF_TXDATA);
   assign w_wr_irqclr = w_wr && (w_off == OFF_IRQCLR);

   // TCMP == 0 disables the compare so a cleared timer cannot fire.
   assign w_irq_set = (r_tcount == r_tcmp) && (r_tcmp != '0);
   assign w_irq_clr = w_wr_irqclr && i_data[0];

   assign w_push    = w_wr_txdata;
   assign w_pop     = o_tx_valid && i_tx_ready;
   assign w_ovf_set = w_push && w_fifo_full && !w_pop;
   assign w_ovf_clr = w_wr_status && i_data[ST_OVF];

   assign w_count3 = 3'(w_fifo_count);
   assign w_status = pack_status(w_fifo_empty, w_fifo_full, r_irq, w_count3, r_ovf);

   mmio_tx_fifo #(
      .DEPTH     (FIFO_DEPTH)
   ) u_tx_fifo (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_push    (w_push),
      .i_pop     (w_pop),
      .i_wdata   (i_data[7:0]),
      .o_rdata   (o_tx_data),
      .o_empty   (w_fifo_empty),
      .o_full    (w_fifo_full),
      .o_count   (w_fifo_count)
   );

   // Read mux sees register contents before any write on the same edge.
   always_comb begin
      w_rd_data = '0;
      case (w_off)
         OFF_LED:    w_rd_data = {16'h0000, r_led};
         OFF_TCOUNT: w_rd_data = r_tcount;
         OFF_TCMP:   w_rd_data = r_tcmp;
         OFF_STATUS: w_rd_data = w_status;
         default:    w_rd_data = '0;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_q   <= '0;
         r_hit <= 1'b0;
      end else begin
         r_q   <= w_sel ? w_rd_data : 32'h0000_0000;
         r_hit <= w_sel;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_led  <= '0;
         r_tcmp <= '0;
      end else begin
         if (w_wr_led) begin
            r_led <= i_data[15:0];
         end
         if (w_wr_tcmp) begin
            r_tcmp <= i_data;
         end
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_tcount <= '0;
      end else if (w_wr_tcount) begin
         r_tcount <= '0;
      end else begin
         r_tcount <= r_tcount + 32'd1;
      end
   end

   // Both flags are sticky; a set on the same edge as its clear wins.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_irq <= 1'b0;
         r_ovf <= 1'b0;
      end else begin
         r_irq <= w_irq_set || (r_irq && !w_irq_clr);
         r_ovf <= w_ovf_set || (r_ovf && !w_ovf_clr);
      end
   end

   assign o_q        = r_q;
   assign o_hit      = r_hit;
   assign o_led_out  = r_led;
   assign o_tx_valid = !w_fifo_empty;
   assign o_irq      = r_irq;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// behavioural model of the register window, timer, irq and TX queue.
module tb_dmem_mmio_responder;

   localparam logic [11:0] BASE  = 12'hFF0;
   localparam int          DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] address = '0;
   logic [31:0] data = '0;
   logic        wren = 1'b0;
   logic        tx_ready = 1'b0;
   logic [31:0] q;
   logic        hit;
   logic [15:0] led_out;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        irq;

   int tests_run = 0;
   int tests_failed = 0;

   logic [15:0] m_led;
   logic [31:0] m_tcount;
   logic [31:0] m_tcmp;
   bit          m_irq;
   bit          m_ovf;
   logic [7:0]  m_fifo [$];
   logic [31:0] m_q;
   bit          m_hit;

   always #5 clk = ~clk;

   dmem_mmio_responder dut (
      .i_clock    (clk),
      .i_reset_n  (rst_n),
      .i_address  (address),
      .i_data     (data),
      .i_wren     (wren),
      .o_q        (q),
      .o_hit      (hit),
      .o_led_out  (led_out),
      .o_tx_data  (tx_data),
      .o_tx_valid (tx_valid),
      .i_tx_ready (tx_ready),
      .o_irq      (irq)
   );

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      address = a; data = d; wren = 1'b1;
      @(posedge clk); #1;
      $display("[TB] wr addr=%h data=%h", a, d);
      wren = 1'b0; address = 12'h000;
   endtask

   task automatic rd(input logic [11:0] a);
      address = a; wren = 1'b0;
      @(posedge clk); #1;
      $display("[TB] rd addr=%h q=%h hit=%0b", a, q, hit);
   endtask

   task automatic idle(input int n);
      address = 12'h000; wren = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      #3;
      tests_run++; if (q !== 32'h0) begin tests_failed++; $display("FAIL reset_q got %h want 0", q); end
      tests_run++; if (hit !== 1'b0) begin tests_failed++; $display("FAIL reset_hit got %b want 0", hit); end
      tests_run++; if (led_out !== 16'h0) begin tests_failed++; $display("FAIL reset_led got %h want 0", led_out); end
      tests_run++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx got v=%b d=%h want 0/00", tx_valid, tx_data); end
      tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq got %b want 0", irq); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_led();
      wr(12'hFF0, 32'h0001_ABCD);
      rd(12'hFF0);
      tests_run++; if (q !== 32'h0000_ABCD) begin tests_failed++; $display("FAIL led_q got %h want 0000abcd", q); end
      tests_run++; if (hit !== 1'b1) begin tests_failed++; $display("FAIL led_hit got %b want 1", hit); end
      tests_run++; if (led_out !== 16'hABCD) begin tests_failed++; $display("FAIL led_out got %h want abcd", led_out); end
      rd(12'h100);
      tests_run++; if (hit !== 1'b0 || q !== 32'h0) begin tests_failed++; $display("FAIL miss_read got hit=%b q=%h want 0/0", hit, q); end
   endtask

   task automatic test_timer_irq();
      idle(10);
      wr(12'hFF2, 32'd5);
      wr(12'hFF1, 32'd0);
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_early edge %0d got %b want 0", k, irq); end
      end
      @(posedge clk); #1;
      tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL irq_rise got %b want 1", irq); end
      wr(12'hFF5, 32'd1);
      tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_clear got %b want 0", irq); end
      wr(12'hFF1, 32'd0);
      idle(5);
      wr(12'hFF5, 32'd1);
      tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL irq_set_wins got %b want 1", irq); end
      wr(12'hFF2, 32'd0);
      wr(12'hFF5, 32'd1);
      tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_final_clear got %b want 0", irq); end
   endtask

   task automatic test_fifo_fill();
      logic [7:0] exp_b [4];
      exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) wr(12'hFF4, {24'h0, exp_b[i]});
      rd(12'hFF3);
      tests_run++; if (q !== 32'h0000_0022) begin tests_failed++; $display("FAIL fill_status got %h want 00000022", q); end
      wr(12'hFF4, 32'h55);
      rd(12'hFF3);
      tests_run++; if (q !== 32'h0000_0062) begin tests_failed++; $display("FAIL overflow_status got %h want 00000062", q); end
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tests_run++; if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin tests_failed++; $display("FAIL drain_%0d got v=%b d=%h want 1/%h", i, tx_valid, tx_data, exp_b[i]); end
         @(posedge clk); #1;
      end
      tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_empty got %b want 0", tx_valid); end
      tx_ready = 1'b0;
      wr(12'hFF3, 32'h40);
      rd(12'hFF3);
      tests_run++; if (q !== 32'h0000_0001) begin tests_failed++; $display("FAIL ovf_clear_status got %h want 00000001", q); end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] b [5];
      for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
      b[4] = 8'h66;
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) wr(12'hFF4, {24'h0, b[i]});
      address = 12'hFF4; data = 32'h66; wren = 1'b1; tx_ready = 1'b1;
      @(posedge clk); #1;
      wren = 1'b0; tx_ready = 1'b0; address = 12'h000;
      tests_run++; if (tx_valid !== 1'b1 || tx_data !== b[1]) begin tests_failed++; $display("FAIL fullpp_head got v=%b d=%h want 1/%h", tx_valid, tx_data, b[1]); end
      rd(12'hFF3);
      tests_run++; if (q !== 32'h0000_0022) begin tests_failed++; $display("FAIL fullpp_status got %h want 00000022", q); end
      tx_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         tests_run++; if (tx_valid !== 1'b1 || tx_data !== b[i]) begin tests_failed++; $display("FAIL fullpp_drain_%0d got v=%b d=%h want 1/%h", i, tx_valid, tx_data, b[i]); end
         @(posedge clk); #1;
      end
      tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL fullpp_empty got %b want 0", tx_valid); end
      wr(12'hFF4, 32'h77);
      tests_run++; if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin tests_failed++; $display("FAIL emptypp got v=%b d=%h want 1/77", tx_valid, tx_data); end
      @(posedge clk); #1;
      tx_ready = 1'b0;
      rd(12'hFF3);
      tests_run++; if (q !== 32'h0000_0001) begin tests_failed++; $display("FAIL emptypp_status got %h want 00000001", q); end
   endtask

   task automatic test_timer_count();
      wr(12'hFF2, 32'd0);
      wr(12'hFF1, 32'd0);
      address = 12'hFF1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         tests_run++; if (q !== 32'(k) || irq !== 1'b0) begin tests_failed++; $display("FAIL tcount_%0d got q=%h irq=%b want %h/0", k, q, irq, 32'(k)); end
      end
      address = 12'h000;
   endtask

   task automatic test_async_reset();
      wr(12'hFF2, 32'd3);
      wr(12'hFF1, 32'd0);
      idle(5);
      tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL arst_pre_irq got %b want 1", irq); end
      wr(12'hFF0, 32'h1234);
      for (int i = 0; i < 3; i++) wr(12'hFF4, 32'hA0 + 32'(i));
      address = 12'hFF0; tx_ready = 1'b1;
      @(posedge clk); #1;
      tests_run++; if (q !== 32'h1234 || hit !== 1'b1 || tx_data !== 8'hA1) begin tests_failed++; $display("FAIL arst_pre got q=%h hit=%b d=%h want 1234/1/a1", q, hit, tx_data); end
      #2; rst_n = 1'b0; #1;
      tests_run++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin tests_failed++; $display("FAIL arst_tx got v=%b d=%h want 0/00", tx_valid, tx_data); end
      tests_run++; if (q !== 32'h0 || hit !== 1'b0) begin tests_failed++; $display("FAIL arst_q got q=%h hit=%b want 0/0", q, hit); end
      tests_run++; if (led_out !== 16'h0 || irq !== 1'b0) begin tests_failed++; $display("FAIL arst_led_irq got led=%h irq=%b want 0/0", led_out, irq); end
      tx_ready = 1'b0; address = 12'h000;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_random();
      bit          in_win, we, irq_set, irq_clr, ovf_set, ovf_clr;
      int          o, n, r;
      logic [31:0] rv;
      rst_n = 1'b0; wren = 1'b0; tx_ready = 1'b0; address = 12'h000;
      @(negedge clk); rst_n = 1'b1;
      m_led = '0; m_tcount = '0; m_tcmp = '0; m_irq = 0; m_ovf = 0; m_fifo.delete();
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         if (r < 3)      address = BASE + 12'd4;
         else if (r < 8) address = BASE + 12'($urandom_range(0, 5));
         else if (r < 9) address = BASE + 12'($urandom_range(0, 15));
         else            address = 12'($urandom);
         wren = ($urandom_range(0, 4) < 2);
         case ($urandom_range(0, 2))
            0:       data = $urandom;
            1:       data = $urandom_range(0, 15);
            default: data = $urandom_range(0, 127);
         endcase
         tx_ready = ($urandom_range(0, 99) < ((i < 150) ? 10 : 50));

         in_win = (address >= BASE) && (address <= BASE + 12'd15);
         o  = int'(address) - int'(BASE);
         n  = m_fifo.size();
         we = wren && in_win;
         rv = '0;
         if (in_win) begin
            case (o)
               0: rv = {16'h0, m_led};
               1: rv = m_tcount;
               2: rv = m_tcmp;
               3: rv = 32'((n == 0 ? 1 : 0) + (n == DEPTH ? 2 : 0) + (m_irq ? 4 : 0) + 8 * n + (m_ovf ? 64 : 0));
               default: rv = '0;
            endcase
         end
         irq_set = (m_tcount == m_tcmp) && (m_tcmp != 0);
         irq_clr = we && o == 5 && data[0];
         ovf_clr = we && o == 3 && data[6];
         ovf_set = 0;
         if (n > 0 && tx_ready) void'(m_fifo.pop_front());
         if (we && o == 0) m_led = data[15:0];
         if (we && o == 2) m_tcmp = data;
         if (we && o == 4) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(data[7:0]);
            else ovf_set = 1;
         end
         m_tcount = (we && o == 1) ? 32'd0 : m_tcount + 32'd1;
         m_irq = irq_set || (m_irq && !irq_clr);
         m_ovf = ovf_set || (m_ovf && !ovf_clr);
         m_q   = in_win ? rv : 32'h0;
         m_hit = in_win;

         @(posedge clk); #1;
         $display("[TB] rnd %0d addr=%h wren=%b data=%h rdy=%b q=%h", i, address, wren, data, tx_ready, q);
         tests_run++; if (q !== m_q) begin tests_failed++; $display("FAIL rnd_q cycle %0d got %h want %h", i, q, m_q); end
         tests_run++; if (hit !== m_hit) begin tests_failed++; $display("FAIL rnd_hit cycle %0d got %b want %b", i, hit, m_hit); end
         tests_run++; if (led_out !== m_led) begin tests_failed++; $display("FAIL rnd_led cycle %0d got %h want %h", i, led_out, m_led); end
         tests_run++; if (tx_valid !== (m_fifo.size() > 0)) begin tests_failed++; $display("FAIL rnd_valid cycle %0d got %b want %b", i, tx_valid, m_fifo.size() > 0); end
         if (m_fifo.size() > 0) begin
            tests_run++; if (tx_data !== m_fifo[0]) begin tests_failed++; $display("FAIL rnd_txdata cycle %0d got %h want %h", i, tx_data, m_fifo[0]); end
         end
         tests_run++; if (irq !== m_irq) begin tests_failed++; $display("FAIL rnd_irq cycle %0d got %b want %b", i, irq, m_irq); end
      end
      wren = 1'b0; tx_ready = 1'b0; address = 12'h000;
   endtask

   initial begin
      test_reset();
      test_led();
      test_timer_irq();
      test_fifo_fill();
      test_full_push_pop();
      test_timer_count();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
